// File: rtl/aes_axil_ctrl_regs.sv
`timescale 1ns/1ps
// aes_axil_ctrl_regs: AXI4-Lite register bank and start/done sequencer
// for the AES encoder core (key, plaintext, ciphertext, ctrl, status).
module aes_axil_ctrl_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_KEY_WORDS        = 4,
  parameter int C_BLOCK_WORDS      = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*C_KEY_WORDS-1:0]       key_o,
  output logic [32*C_BLOCK_WORDS-1:0]     pt_o,
  output logic                            start_o,
  input  logic                            busy_i,
  input  logic                            done_i,
  input  logic [32*C_BLOCK_WORDS-1:0]     ct_i,
  output logic                            irq_o
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int K  = C_KEY_WORDS;
  localparam int B  = C_BLOCK_WORDS;

  localparam logic [31:0] L_KEY = 32'd2;
  localparam logic [31:0] L_PT  = 32'(2 + K);
  localparam logic [31:0] L_CT  = 32'(2 + K + B);
  localparam logic [31:0] L_NW  = 32'(2 + K + 2 * B);

  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  logic          r_aw_full;
  logic [AW-3:0] r_aw_idx;
  logic          r_w_full;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_bvalid;
  logic [1:0]    r_bresp;

  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic [1:0]    r_rresp;

  logic [31:0]   r_key [K];
  logic [31:0]   r_pt  [B];
  logic [31:0]   r_ct  [B];
  logic          r_irq_en;
  logic          r_done;
  logic          r_start;
  logic          r_irq;

  logic          w_awready;
  logic          w_wready;
  logic          w_arready;
  logic          w_do_write;
  logic [31:0]   w_wi;
  logic [31:0]   w_ri;
  logic [31:0]   w_bmask;
  logic [1:0]    w_bresp;
  logic          w_sel_ctrl;
  logic          w_sel_stat;
  logic          w_sel_key;
  logic          w_sel_pt;
  logic [31:0]   w_rdata;
  logic [1:0]    w_rresp;
  logic          w_unused;

  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
    end
    return m;
  endfunction

  // Single outstanding write: no new address/data while a response waits.
  assign w_awready  = ~ARESET & ~r_aw_full & ~r_bvalid;
  assign w_wready   = ~ARESET & ~r_w_full  & ~r_bvalid;
  assign w_arready  = ~ARESET & ~r_rvalid;
  assign w_do_write = r_aw_full & r_w_full & ~r_bvalid;

  assign w_wi    = 32'(r_aw_idx);
  assign w_ri    = 32'(S_AXI_ARADDR[AW-1:2]);
  assign w_bmask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}},
                    {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Classify the held write: target register and response code
  always_comb begin
    w_bresp    = RESP_OK;
    w_sel_ctrl = 1'b0;
    w_sel_stat = 1'b0;
    w_sel_key  = 1'b0;
    w_sel_pt   = 1'b0;
    unique case (1'b1)
      (w_wi == 32'd0): w_sel_ctrl = 1'b1;
      (w_wi == 32'd1): begin
        if ((r_wdata & w_bmask & ~32'h2) != 32'd0) w_bresp = RESP_ERR;
        else w_sel_stat = 1'b1;
      end
      (w_wi >= L_KEY && w_wi < L_PT): begin
        if (busy_i) w_bresp = RESP_ERR;
        else w_sel_key = 1'b1;
      end
      (w_wi >= L_PT && w_wi < L_CT): begin
        if (busy_i) w_bresp = RESP_ERR;
        else w_sel_pt = 1'b1;
      end
      default: w_bresp = RESP_ERR;
    endcase
  end

  // Read mux over the compacted register map
  always_comb begin
    w_rdata = 32'd0;
    w_rresp = RESP_OK;
    unique case (1'b1)
      (w_ri == 32'd0): w_rdata = {30'd0, r_irq_en, 1'b0};
      (w_ri == 32'd1): w_rdata = {30'd0, r_done, busy_i};
      (w_ri >= L_KEY && w_ri < L_PT): begin
        for (int k = 0; k < K; k++) begin
          if (w_ri == L_KEY + 32'(k)) w_rdata = r_key[k];
        end
      end
      (w_ri >= L_PT && w_ri < L_CT): begin
        for (int k = 0; k < B; k++) begin
          if (w_ri == L_PT + 32'(k)) w_rdata = r_pt[k];
        end
      end
      (w_ri >= L_CT && w_ri < L_NW): begin
        for (int k = 0; k < B; k++) begin
          if (w_ri == L_CT + 32'(k)) w_rdata = r_ct[k];
        end
      end
      default: w_rresp = RESP_ERR;
    endcase
  end

  // Write channel: independent AW/W holders retired into one response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OK;
    end else begin
      if (S_AXI_AWVALID && w_awready) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= S_AXI_AWADDR[AW-1:2];
      end
      if (S_AXI_WVALID && w_wready) begin
        r_w_full <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      if (w_do_write) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_bresp;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Register file, start pulse and ciphertext capture
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < K; k++) r_key[k] <= '0;
      for (int k = 0; k < B; k++) r_pt[k] <= '0;
      for (int k = 0; k < B; k++) r_ct[k] <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_start  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_do_write) begin
        if (w_sel_ctrl && r_wstrb[0]) begin
          r_irq_en <= r_wdata[1];
          r_start  <= r_wdata[0] & ~busy_i;
        end
        if (w_sel_stat && r_wstrb[0] && r_wdata[1]) r_done <= 1'b0;
        for (int k = 0; k < K; k++) begin
          if (w_sel_key && w_wi == L_KEY + 32'(k))
            r_key[k] <= f_merge(r_key[k], r_wdata, r_wstrb);
        end
        for (int k = 0; k < B; k++) begin
          if (w_sel_pt && w_wi == L_PT + 32'(k))
            r_pt[k] <= f_merge(r_pt[k], r_wdata, r_wstrb);
        end
      end
      // A completion in the same cycle as a DONE clear wins
      if (done_i) begin
        r_done <= 1'b1;
        for (int k = 0; k < B; k++) r_ct[k] <= ct_i[32*k +: 32];
      end
    end
  end

  // Read channel: registered data held stable until RREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OK;
    end else if (S_AXI_ARVALID && w_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_rresp  <= w_rresp;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  // Level interrupt from sticky DONE gated by IRQ_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) r_irq <= 1'b0;
    else        r_irq <= r_done & r_irq_en;
  end

  for (genvar g = 0; g < K; g++) begin : g_key
    assign key_o[32*g +: 32] = r_key[g];
  end
  for (genvar g = 0; g < B; g++) begin : g_pt
    assign pt_o[32*g +: 32] = r_pt[g];
  end

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign start_o       = r_start;
  assign irq_o         = r_irq;

endmodule

// File: tb/tb_aes_axil_ctrl_regs.sv
`timescale 1ns/1ps
// tb_aes_axil_ctrl_regs: directed bench for the AES AXI4-Lite register
// bank (map, strobes, start/done, errors, backpressure, reset).
module tb_aes_axil_ctrl_regs;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [5:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] key_o;
  logic [127:0] pt_o;
  logic         start_o;
  logic         busy_i = 1'b0;
  logic         done_i = 1'b0;
  logic [127:0] ct_i = '0;
  logic         irq_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;

  logic [31:0] kv [4] = '{32'h2b7e1516, 32'h28aed2a6,
                          32'habf71588, 32'h09cf4f3c};
  logic [31:0] pv [4] = '{32'h3243f6a8, 32'h885a308d,
                          32'h313198a2, 32'he0370734};
  logic [127:0] ctv = 128'h3925841d02dc09fbdc118597196a0b32;
  logic [31:0]  ctw [4] = '{32'h196a0b32, 32'hdc118597,
                            32'h02dc09fb, 32'h3925841d};

  aes_axil_ctrl_regs dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .key_o(key_o), .pt_o(pt_o), .start_o(start_o),
    .busy_i(busy_i), .done_i(done_i), .ct_i(ct_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_o) n_start++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_ok, w_ok, b_ok;
    aw_ok = 0; w_ok = 0; b_ok = 0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int n = 0; n < 20 && !(aw_ok && w_ok); n++) begin
      @(negedge clk);
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      tick();
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
    end
    for (int n = 0; n < 20 && !b_ok; n++) begin
      @(negedge clk);
      if (bvalid) begin
        b_ok = 1;
        resp = bresp;
      end
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    chk("wr_handshake", {aw_ok, w_ok, b_ok}, 3'b111);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    bit ar_ok, r_ok;
    ar_ok = 0; r_ok = 0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int n = 0; n < 20 && !ar_ok; n++) begin
      @(negedge clk);
      if (arready) ar_ok = 1;
      tick();
    end
    arvalid = 1'b0;
    for (int n = 0; n < 20 && !r_ok; n++) begin
      @(negedge clk);
      if (rvalid) begin
        r_ok = 1;
        d = rdata;
        resp = rresp;
      end
      tick();
    end
    rready = 1'b0;
    chk("rd_handshake", {ar_ok, r_ok}, 2'b11);
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  logic [1:0]  bs;
  int          n0;
  bit          seen;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_start", start_o, 1'b0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_key", key_o, 128'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", awready, 1'b1);
    chk("post_rst_wready", wready, 1'b1);
    chk("post_rst_arready", arready, 1'b1);

    // W three cycles ahead of AW, strobed write to PT1
    tick();
    wdata = 32'hffffffff; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_wready", wready, 1'b1);
    tick();
    wvalid = 1'b0;
    repeat (2) tick();
    awaddr = 6'h1c; awvalid = 1'b1;
    @(negedge clk);
    chk("wfirst_awready", awready, 1'b1);
    chk("wfirst_no_bvalid_early", bvalid, 1'b0);
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_bvalid_lat0", bvalid, 1'b0);
    tick();
    @(negedge clk);
    chk("wfirst_bvalid_lat1", bvalid, 1'b1);
    chk("wfirst_bresp", bresp, 2'b00);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    @(negedge clk);
    chk("wfirst_bvalid_drop", bvalid, 1'b0);

    // AW two cycles ahead of W, strobed write to PT2
    tick();
    awaddr = 6'h20; awvalid = 1'b1;
    @(negedge clk);
    chk("awfirst_awready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    tick();
    wdata = 32'hffffffff; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge clk);
    chk("awfirst_no_bvalid_early", bvalid, 1'b0);
    tick();
    wvalid = 1'b0;
    @(negedge clk);
    chk("awfirst_bvalid_lat0", bvalid, 1'b0);
    tick();
    @(negedge clk);
    chk("awfirst_bvalid_lat1", bvalid, 1'b1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(6'h1c, rd, rs);
    chk("pt1_strobe", rd, 32'h00ff00ff);
    axi_read(6'h20, rd, rs);
    chk("pt2_strobe", rd, 32'h00ff00ff);

    // full key and plaintext load and readback
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(8 + 4 * i), kv[i], 4'hf, bs);
      chk("key_wr_resp", bs, 2'b00);
      axi_write(6'(24 + 4 * i), pv[i], 4'hf, bs);
      chk("pt_wr_resp", bs, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(8 + 4 * i), rd, rs);
      chk("key_rd", rd, kv[i]);
      chk("key_rd_resp", rs, 2'b00);
      axi_read(6'(24 + 4 * i), rd, rs);
      chk("pt_rd", rd, pv[i]);
      chk("pt_rd_resp", rs, 2'b00);
    end
    chk("key_o", key_o, {kv[3], kv[2], kv[1], kv[0]});
    chk("pt_o", pt_o, {pv[3], pv[2], pv[1], pv[0]});

    // start pulse, core completion, interrupt
    axi_write(6'h00, 32'h3, 4'hf, bs);
    chk("ctrl_wr_resp", bs, 2'b00);
    repeat (3) tick();
    chk("start_single", n_start, 1);
    busy_i = 1'b1;
    axi_read(6'h04, rd, rs);
    chk("status_busy", rd, 32'h1);
    tick();
    done_i = 1'b1; ct_i = ctv; busy_i = 1'b0;
    tick();
    done_i = 1'b0; ct_i = '0;
    repeat (2) tick();
    chk("irq_set", irq_o, 1'b1);
    axi_read(6'h04, rd, rs);
    chk("status_done", rd, 32'h2);
    axi_read(6'h00, rd, rs);
    chk("ctrl_readback", rd, 32'h2);
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(40 + 4 * i), rd, rs);
      chk("ct_rd", rd, ctw[i]);
    end
    axi_write(6'h04, 32'h2, 4'hf, bs);
    chk("w1c_resp", bs, 2'b00);
    repeat (2) tick();
    chk("irq_clear", irq_o, 1'b0);
    axi_read(6'h04, rd, rs);
    chk("status_cleared", rd, 32'h0);

    // core busy: key write refused, start ignored
    busy_i = 1'b1;
    axi_write(6'h10, 32'hdeadbeef, 4'hf, bs);
    chk("busy_key_slverr", bs, 2'b10);
    axi_read(6'h10, rd, rs);
    chk("busy_key_kept", rd, 32'habf71588);
    chk("busy_key_o", key_o[95:64], 32'habf71588);
    n0 = n_start;
    axi_write(6'h00, 32'h1, 4'hf, bs);
    chk("busy_start_resp", bs, 2'b00);
    repeat (3) tick();
    chk("busy_no_start", n_start, n0);
    busy_i = 1'b0;

    // out-of-range and read-only targets
    axi_read(6'h3c, rd, rs);
    chk("oob_rdata", rd, 32'h0);
    chk("oob_rresp", rs, 2'b10);
    axi_read(6'h38, rd, rs);
    chk("oob_edge_rresp", rs, 2'b10);
    axi_write(6'h28, 32'h12345678, 4'hf, bs);
    chk("ct_wr_slverr", bs, 2'b10);
    axi_read(6'h28, rd, rs);
    chk("ct_unchanged", rd, 32'h196a0b32);
    axi_write(6'h04, 32'h1, 4'hf, bs);
    chk("status_ro_slverr", bs, 2'b10);

    // arm irq so reset has something to clear
    axi_write(6'h00, 32'h2, 4'hf, bs);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    repeat (2) tick();
    chk("irq_rearm", irq_o, 1'b1);

    // write response backpressure
    busy_i = 1'b1;
    awaddr = 6'h08; wdata = 32'h11111111; wstrb = 4'hf;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("bp_aw_w_ready", {awready, wready}, 2'b11);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bvalid) seen = 1;
      else tick();
    end
    chk("bp_bvalid_seen", seen, 1'b1);
    for (int n = 0; n < 5; n++) begin
      tick();
      @(negedge clk);
      chk("bp_bvalid_hold", bvalid, 1'b1);
      chk("bp_bresp_hold", bresp, 2'b10);
      chk("bp_awready_low", awready, 1'b0);
      chk("bp_wready_low", wready, 1'b0);
    end
    tick();
    bready = 1'b1;
    tick();
    bready = 1'b0;
    busy_i = 1'b0;

    // read data backpressure
    araddr = 6'h0c; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    chk("bp_arready", arready, 1'b1);
    tick();
    arvalid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_rvalid_hold", rvalid, 1'b1);
      chk("bp_rdata_hold", rdata, 32'h28aed2a6);
      chk("bp_rresp_hold", rresp, 2'b00);
      chk("bp_arready_low", arready, 1'b0);
      tick();
    end

    // reset with a read held and an address parked in the holder
    awaddr = 6'h08; awvalid = 1'b1;
    @(negedge clk);
    chk("park_awready", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_awready", awready, 1'b0);
    tick();
    @(negedge clk);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_resps", {rresp, bresp}, 4'h0);
    chk("mid_rst_irq", irq_o, 1'b0);
    chk("mid_rst_start", start_o, 1'b0);
    chk("mid_rst_key", key_o, 128'h0);
    chk("mid_rst_pt", pt_o, 128'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_ready", {awready, wready, arready}, 3'b111);
    tick();
    wdata = 32'h55555555; wstrb = 4'hf; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("holder_flushed", bvalid, 1'b0);
    chk("holder_key0", key_o[31:0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
